// File: rtl/noc_out_port_arbiter.sv
// Purpose : round-robin output-port scheduler; pops one input FIFO per cycle onto a shared link.
// Latency : 1 cycle from fifo_rd_en pop to out_valid/out_data.
// Backpress: credit-based; no pop while credit_cnt == 0, requests (and any packet lock) are held.
//
// Ports:
//   clk, reset      - clock and synchronous active-high reset
//   fifo_empty      - per-port empty flags (bit i = port i)
//   fifo_data       - FWFT head flit of each port, port i at [i*FLIT_WIDTH +: FLIT_WIDTH]
//   fifo_rd_en      - combinational one-hot pop strobe
//   credit_in       - one pulse per downstream slot freed
//   out_data/valid  - registered forwarded flit, valid is a one-cycle pulse per flit
//   grant           - registered one-hot owner, 0 when idle
//   credit_cnt      - current downstream credit count
//   credit_err      - sticky credit overflow flag
//
// Build option ARB_PKT_LOCK_EN: when defined, a multi-flit packet keeps the link
// (wormhole lock) until its tail flit is popped; when undefined every flit is
// arbitrated on its own and grant pulses once per pop.
module noc_out_port_arbiter #(
  parameter int FLIT_WIDTH = 32,
  parameter int NUM_PORTS  = 4,
  parameter int CREDITS    = 8
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_PORTS-1:0]              fifo_empty,
  input  logic [NUM_PORTS*FLIT_WIDTH-1:0]   fifo_data,
  output logic [NUM_PORTS-1:0]              fifo_rd_en,
  input  logic                              credit_in,
  output logic [FLIT_WIDTH-1:0]             out_data,
  output logic                              out_valid,
  output logic [NUM_PORTS-1:0]              grant,
  output logic [$clog2(CREDITS+1)-1:0]      credit_cnt,
  output logic                              credit_err
);

  localparam int              PW   = $clog2(NUM_PORTS);
  localparam int              CW   = $clog2(CREDITS + 1);
  localparam logic [PW:0]     NP   = (PW+1)'(NUM_PORTS);
  localparam logic [PW-1:0]   LAST = PW'(NUM_PORTS - 1);
  localparam logic [CW-1:0]   CMAX = CW'(CREDITS);

  logic [PW-1:0]         r_ptr;
  logic [NUM_PORTS-1:0]  r_grant;
  logic [FLIT_WIDTH-1:0] r_out_data;
  logic                  r_out_valid;
  logic [CW-1:0]         r_credit_cnt;
  logic                  r_credit_err;

`ifdef ARB_PKT_LOCK_EN
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_LOCKED = 1'b1;
  logic [0:0]    r_state;
  logic [PW-1:0] r_owner;
`endif

  logic [PW:0]           w_idx;
  logic                  w_found;
  logic [PW-1:0]         w_win;
  logic [PW-1:0]         w_sel;
  logic                  w_req;
  logic                  w_issue;
  logic [FLIT_WIDTH-1:0] w_flit;
  logic                  w_tail;
  logic [NUM_PORTS-1:0]  w_sel_oh;
  logic [PW-1:0]         w_next_ptr;

  // Round-robin search: first non-empty port at or after r_ptr, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(i);
      if (w_idx >= NP) w_idx = w_idx - NP;
      if (!w_found && !fifo_empty[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[PW-1:0];
      end
    end
  end

`ifdef ARB_PKT_LOCK_EN
  // While locked only the owner may be served, even if it is empty.
  assign w_sel = (r_state == S_LOCKED) ? r_owner : w_win;
  assign w_req = (r_state == S_LOCKED) ? ~fifo_empty[r_owner] : w_found;
`else
  assign w_sel = w_win;
  assign w_req = w_found;
`endif

  // Reset gates the pop so nothing is lost from a FIFO in the reset cycle.
  assign w_issue = w_req && (r_credit_cnt != '0) && !reset;

  always_comb begin
    w_flit   = '0;
    w_sel_oh = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_sel == PW'(i)) begin
        w_flit      = fifo_data[i*FLIT_WIDTH +: FLIT_WIDTH];
        w_sel_oh[i] = 1'b1;
      end
    end
  end

  assign w_tail     = w_flit[FLIT_WIDTH-2];
  assign w_next_ptr = (w_sel == LAST) ? '0 : w_sel + 1'b1;
  assign fifo_rd_en = w_issue ? w_sel_oh : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr        <= '0;
      r_grant      <= '0;
      r_out_data   <= '0;
      r_out_valid  <= 1'b0;
      r_credit_cnt <= CMAX;
      r_credit_err <= 1'b0;
`ifdef ARB_PKT_LOCK_EN
      r_state      <= S_IDLE;
      r_owner      <= '0;
`endif
    end else begin
      r_out_valid <= w_issue;
      if (w_issue) r_out_data <= w_flit;

      // A pop and a returned credit in the same cycle cancel out.
      if (w_issue && !credit_in) begin
        r_credit_cnt <= r_credit_cnt - 1'b1;
      end else if (credit_in && !w_issue) begin
        if (r_credit_cnt == CMAX) r_credit_err <= 1'b1;
        else                      r_credit_cnt <= r_credit_cnt + 1'b1;
      end

`ifdef ARB_PKT_LOCK_EN
      if (r_state == S_IDLE) begin
        r_grant <= '0;
        if (w_issue) begin
          if (w_tail) begin
            r_ptr <= w_next_ptr;
          end else begin
            // Pointer stays put until the tail leaves.
            r_state <= S_LOCKED;
            r_owner <= w_sel;
            r_grant <= w_sel_oh;
          end
        end
      end else if (w_issue && w_tail) begin
        r_state <= S_IDLE;
        r_grant <= '0;
        r_ptr   <= w_next_ptr;
      end
`else
      r_grant <= w_issue ? w_sel_oh : '0;
      if (w_issue) r_ptr <= w_next_ptr;
`endif
    end
  end

  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign grant      = r_grant;
  assign credit_cnt = r_credit_cnt;
  assign credit_err = r_credit_err;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Purpose : directed self-checking bench for noc_out_port_arbiter (main 8-credit instance plus a 2-credit instance).
// Latency : checks sample 2 time units after each posedge; pops are modelled from fifo_rd_en seen at negedge.
// Backpress: credit_in / credit_in2 driven directly by the stimulus sequence.
module tb_noc_out_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   fifo_empty;
  logic [127:0] fifo_data;
  logic [3:0]   fifo_rd_en;
  logic         credit_in;
  logic [31:0]  out_data;
  logic         out_valid;
  logic [3:0]   grant;
  logic [3:0]   credit_cnt;
  logic         credit_err;

  logic [3:0]   fifo_empty2;
  logic [127:0] fifo_data2;
  logic [3:0]   fifo_rd_en2;
  logic         credit_in2;
  logic [31:0]  out_data2;
  logic         out_valid2;
  logic [3:0]   grant2;
  logic [1:0]   credit_cnt2;
  logic         credit_err2;

  always #5 clk = ~clk;

  noc_out_port_arbiter #(.FLIT_WIDTH(32), .NUM_PORTS(4), .CREDITS(8)) u_dut (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
    .fifo_rd_en(fifo_rd_en), .credit_in(credit_in), .out_data(out_data),
    .out_valid(out_valid), .grant(grant), .credit_cnt(credit_cnt), .credit_err(credit_err)
  );

  noc_out_port_arbiter #(.FLIT_WIDTH(32), .NUM_PORTS(4), .CREDITS(2)) u_dut2 (
    .clk(clk), .reset(reset), .fifo_empty(fifo_empty2), .fifo_data(fifo_data2),
    .fifo_rd_en(fifo_rd_en2), .credit_in(credit_in2), .out_data(out_data2),
    .out_valid(out_valid2), .grant(grant2), .credit_cnt(credit_cnt2), .credit_err(credit_err2)
  );

  // Per-port FIFO model for the main instance; port 0 counter model for the 2-credit one.
  logic [31:0] mem [4][8];
  int rp [4];
  int wp [4];
  int cnt2;
  int pops2;
  int last_pop;

  int n_total = 0;
  int n_fail  = 0;

`ifdef ARB_PKT_LOCK_EN
  int          exp_port [6] = '{1, 1, 1, 2, 2, 2};
  logic [3:0]  exp_gnt  [6] = '{4'h2, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0};
  logic [31:0] exp_dat  [6] = '{32'h8000_0001, 32'h0000_0002, 32'h4000_0003,
                                32'hC000_0B01, 32'hC000_0B02, 32'hC000_0B03};
  logic [3:0]  exp_gnt2 = 4'h0;
`else
  int          exp_port [6] = '{1, 2, 1, 2, 1, 2};
  logic [3:0]  exp_gnt  [6] = '{4'h2, 4'h4, 4'h2, 4'h4, 4'h2, 4'h4};
  logic [31:0] exp_dat  [6] = '{32'h8000_0001, 32'hC000_0B01, 32'h0000_0002,
                                32'hC000_0B02, 32'h4000_0003, 32'hC000_0B03};
  logic [3:0]  exp_gnt2 = 4'h1;
`endif

  function automatic logic [3:0] oh(input int p);
    return 4'(1 << p);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      fifo_empty[i] = (rp[i] == wp[i]);
      fifo_data[i*32 +: 32] = (rp[i] == wp[i]) ? 32'h0 : mem[i][rp[i]];
    end
    fifo_empty2 = {3'b111, (cnt2 == 0)};
    fifo_data2  = '0;
    fifo_data2[31:0] = 32'hC000_0200 + 32'(cnt2);
  endtask

  task automatic apply();
    drive();
    #1;
  endtask

  task automatic load(input int p, input logic [31:0] v);
    mem[p][wp[p]] = v;
    wp[p]++;
  endtask

  task automatic clear_q();
    for (int i = 0; i < 4; i++) begin
      rp[i] = 0;
      wp[i] = 0;
    end
    cnt2 = 0;
  endtask

  // One clock: capture pops before the edge, retire them after it, re-drive inputs.
  task automatic cycle();
    logic [3:0] rd;
    logic [3:0] rd2;
    @(negedge clk);
    rd  = fifo_rd_en;
    rd2 = fifo_rd_en2;
    @(posedge clk);
    #1;
    last_pop = -1;
    for (int i = 0; i < 4; i++) begin
      if (rd[i]) begin
        rp[i]++;
        last_pop = i;
      end
    end
    if (rd2[0]) begin
      cnt2--;
      pops2++;
    end
    apply();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    credit_in = 1'b0;
    credit_in2 = 1'b0;
    clear_q();
    apply();
    cycle();
    cycle();
    reset = 1'b0;
    apply();
  endtask

  initial begin
    reset = 1'b1;
    credit_in = 1'b0;
    credit_in2 = 1'b0;
    cnt2 = 0;
    pops2 = 0;
    last_pop = -1;
    clear_q();
    apply();
    cycle();
    cycle();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_credit_cnt", 32'(credit_cnt), 32'd8);
    check("rst_credit_err", 32'(credit_err), 32'h0);
    reset = 1'b0;
    apply();
    check("idle_rd_en", 32'(fifo_rd_en), 32'h0);

    // Single head+tail flit on port 0
    load(0, 32'hC000_00A1);
    apply();
    check("t1_rd_en", 32'(fifo_rd_en), 32'h1);
    check("t1_valid_before", 32'(out_valid), 32'h0);
    cycle();
    check("t1_out_valid", 32'(out_valid), 32'h1);
    check("t1_out_data", out_data, 32'hC000_00A1);
    check("t1_credit_cnt", 32'(credit_cnt), 32'd7);
    cycle();
    check("t1_valid_pulse", 32'(out_valid), 32'h0);
    check("t1_data_hold", out_data, 32'hC000_00A1);

    // One single-flit packet on every port: served 0,1,2,3
    do_reset();
    for (int i = 0; i < 4; i++) load(i, 32'hC000_1000 + 32'(i));
    apply();
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("t2_pop_port", 32'(last_pop), 32'(i));
      check("t2_out_data", out_data, 32'hC000_1000 + 32'(i));
    end
    check("t2_credit_cnt", 32'(credit_cnt), 32'd4);
    cycle();
    check("t2_idle_valid", 32'(out_valid), 32'h0);

    // Issue together with credit_in leaves the count alone
    load(0, 32'hC000_0055);
    credit_in = 1'b1;
    apply();
    check("t3_rd_en", 32'(fifo_rd_en), 32'h1);
    cycle();
    credit_in = 1'b0;
    apply();
    check("t3_same_cycle_cnt", 32'(credit_cnt), 32'd4);
    check("t3_out_data", out_data, 32'hC000_0055);

    // Refill to the maximum, then overflow
    credit_in = 1'b1;
    apply();
    for (int i = 0; i < 4; i++) cycle();
    check("t3_refill_cnt", 32'(credit_cnt), 32'd8);
    check("t3_no_err_yet", 32'(credit_err), 32'h0);
    cycle();
    credit_in = 1'b0;
    apply();
    check("t3_err_set", 32'(credit_err), 32'h1);
    check("t3_cnt_capped", 32'(credit_cnt), 32'd8);
    cycle();
    cycle();
    check("t3_err_sticky", 32'(credit_err), 32'h1);
    do_reset();
    check("t3_err_cleared", 32'(credit_err), 32'h0);

    // 3-flit packet on port 1 competing with single flits on port 2
    load(1, 32'h8000_0001);
    load(1, 32'h0000_0002);
    load(1, 32'h4000_0003);
    load(2, 32'hC000_0B01);
    load(2, 32'hC000_0B02);
    load(2, 32'hC000_0B03);
    apply();
    for (int k = 0; k < 6; k++) begin
      check("t4_rd_en", 32'(fifo_rd_en), 32'(oh(exp_port[k])));
      cycle();
      check("t4_out_data", out_data, exp_dat[k]);
      check("t4_grant", 32'(grant), 32'(exp_gnt[k]));
    end

    // Reset in the middle of a packet
    do_reset();
    load(1, 32'h8000_0001);
    load(1, 32'h0000_0002);
    load(1, 32'h0000_0003);
    load(1, 32'h4000_0004);
    apply();
    cycle();
    check("t5_head_grant", 32'(grant), 32'h2);
    reset = 1'b1;
    apply();
    check("t5_rd_en_in_reset", 32'(fifo_rd_en), 32'h0);
    cycle();
    check("t5_grant", 32'(grant), 32'h0);
    check("t5_out_valid", 32'(out_valid), 32'h0);
    check("t5_credit_cnt", 32'(credit_cnt), 32'd8);
    check("t5_rd_en", 32'(fifo_rd_en), 32'h0);
    load(0, 32'hC000_00E0);
    reset = 1'b0;
    apply();
    check("t5_restart_port0", 32'(fifo_rd_en), 32'h1);

    // 2-credit instance: 4 flits on port 0
    do_reset();
    reset = 1'b1;
    cnt2 = 4;
    pops2 = 0;
    apply();
    cycle();
    reset = 1'b0;
    apply();
    check("t6_rd_en2_first", 32'(fifo_rd_en2), 32'h1);
    cycle();
    check("t6_out_data2", out_data2, 32'hC000_0204);
    check("t6_grant2", 32'(grant2), 32'(exp_gnt2));
    cycle();
    check("t6_cnt2_zero", 32'(credit_cnt2), 32'd0);
    check("t6_rd_en2_stall", 32'(fifo_rd_en2), 32'h0);
    cycle();
    check("t6_pops2_two", 32'(pops2), 32'd2);
    check("t6_valid2_stall", 32'(out_valid2), 32'h0);
    credit_in2 = 1'b1;
    apply();
    cycle();
    credit_in2 = 1'b0;
    apply();
    check("t6_cnt2_one", 32'(credit_cnt2), 32'd1);
    cycle();
    cycle();
    cycle();
    check("t6_pops2_three", 32'(pops2), 32'd3);
    check("t6_cnt2_zero_again", 32'(credit_cnt2), 32'd0);
    check("t6_err2", 32'(credit_err2), 32'h0);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/noc_out_port_arbiter.md
Name: noc_out_port_arbiter

Overview:
- Output-port scheduler for the Bi-NoC router. Shares one output link between NUM_PORTS input FIFOs using round-robin arbitration.
- Pops the granted FIFO and forwards the flit on a registered output.
- Tracks downstream buffer space with credit-based flow control.
- One instance per router output port; sits between the per-port input FIFO bank and the link driver.

Parameters:
FLIT_WIDTH, 32, flit width in bits; bit FLIT_WIDTH-1 = head flag, bit FLIT_WIDTH-2 = tail flag
NUM_PORTS, 4, number of requesting input FIFOs (2..8)
CREDITS, 8, downstream FIFO depth; reset and maximum value of the credit counter

Ports:
clk  input  1  system clock, all logic on posedge
reset  input  1  synchronous, active-high reset
fifo_empty  input  NUM_PORTS  per-port FIFO empty flag; bit i = port i
fifo_data  input  NUM_PORTS*FLIT_WIDTH  head flit of each FIFO (first-word-fall-through); port i at [i*FLIT_WIDTH +: FLIT_WIDTH]
fifo_rd_en  output  NUM_PORTS  one-hot pop strobe, combinational, at most one bit set
credit_in  input  1  one pulse per slot freed in the downstream FIFO
out_data  output  FLIT_WIDTH  forwarded flit, registered
out_valid  output  1  out_data valid, registered, one-cycle pulse per flit
grant  output  NUM_PORTS  one-hot current owner (registered); 0 when idle
credit_cnt  output  $clog2(CREDITS+1)  current credit count
credit_err  output  1  sticky; set when credit_in arrives with credit_cnt == CREDITS

Behaviour:
Reset values:
- out_data = 0, out_valid = 0, grant = 0.
- credit_cnt = CREDITS, credit_err = 0.
- RR pointer = 0, FSM = IDLE.
- Reset mid-packet discards the lock immediately; no flit is popped in the reset cycle.

Issue condition in cycle N:
- A flit is sent when the selected port is non-empty and credit_cnt > 0.
- fifo_rd_en[sel] = 1 in cycle N.
- At posedge end of N: out_data <= fifo_data[sel], out_valid <= 1. Latency is 1 cycle from pop to out_valid.
- In any cycle without an issue, out_valid = 0 and out_data holds its last value.

Credits:
- Issue decrements credit_cnt; credit_in increments it.
- Issue and credit_in in the same cycle: count unchanged.
- credit_cnt == 0: no issue; requests wait; the lock (if any) is held.
- credit_in at CREDITS without a same-cycle issue: count stays at CREDITS and credit_err is set.

Round-robin arbitration:
- Search non-empty ports starting at the pointer, ascending, wrapping modulo NUM_PORTS.
- After a grant to port w, pointer <= (w+1) mod NUM_PORTS. Exactly when the pointer updates is given under Optional Feature.

FSM:
- IDLE:
  - If any port is non-empty and credit_cnt > 0, grant the RR winner and pop one flit.
  - If that flit's tail bit = 0 and packet lock is enabled: go to LOCKED, grant <= winner.
  - Otherwise stay in IDLE, grant <= 0.
- LOCKED:
  - Only the owner is served; other ports' requests are ignored.
  - Pop when owner non-empty and credit_cnt > 0.
  - Owner empty mid-packet: stall, hold the lock.
  - Popped flit with tail = 1: go to IDLE, grant <= 0, pointer <= owner+1.
- Head bit is not checked for arbitration. A single-flit packet (head = tail = 1) never enters LOCKED.

Optional Feature:
Macro: ARB_PKT_LOCK_EN.
- Defined: wormhole packet locking as in the FSM. The pointer advances only when a packet's tail is popped.
- Undefined:
  - No LOCKED state; every flit is arbitrated independently in IDLE.
  - The pointer advances after every pop.
  - grant is a one-cycle pulse per pop.
  - Flits of different packets may interleave.

Test Plan:
- Reset, then port 0 holds single flit 32'hC000_00A1 (head+tail), credits 8 -> fifo_rd_en=4'b0001 in the first active cycle; next cycle out_valid=1, out_data=32'hC000_00A1; credit_cnt=7.
- All 4 ports hold one single-flit packet each (32'hC000_1000+i) -> pops occur in order 0,1,2,3 on consecutive cycles; out_data sequence 1000,1001,1002,1003 (lower bits); credit_cnt=4.
- ARB_PKT_LOCK_EN defined: port 1 has a 3-flit packet (head 32'h8000_0001, body 32'h0000_0002, tail 32'h4000_0003) and port 2 is non-empty -> all 3 port-1 flits are sent before any port-2 pop; grant=4'b0010 throughout.
- Same stimulus with the macro undefined -> pops alternate between port 1 and port 2.
- Credit exhaustion: CREDITS=2 with 4 queued flits -> 2 pops, then stall with credit_cnt=0. One credit_in pulse -> exactly one more pop.
- Simultaneous issue and credit_in -> credit_cnt unchanged. credit_in at credit_cnt=8 with no issue -> credit_err=1 and stays set until reset.
- Reset asserted in LOCKED mid-packet -> next cycle grant=0, fifo_rd_en=0, credit_cnt=8, out_valid=0. After release, arbitration restarts from port 0.
